// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - Pong ball engine: serve, step, wall/paddle reflection and scoring.
// Optional paddle-hit speed-up is built only when BALL_SPEEDUP_EN is defined.
module ball_engine #(
    parameter int GAME_WIDTH    = 40,
    parameter int GAME_HEIGHT   = 30,
    parameter int COORD_W       = 6,
    parameter int MOVE_TICKS    = 625000,
    parameter int SERVE_TICKS   = 25000000,
    parameter int PADDLE_HEIGHT = 6,
    parameter int SPEEDUP_STEP  = 25000,
    parameter int MIN_TICKS     = 200000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enabled,
    input  logic [COORD_W-1:0] i_col,
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_paddle1_y,
    input  logic [COORD_W-1:0] i_paddle2_y,
    output logic               o_draw,
    output logic [COORD_W-1:0] o_ball_x,
    output logic [COORD_W-1:0] o_ball_y,
    output logic [1:0]         o_ball_direction,
    output logic               o_score_p1,
    output logic               o_score_p2
);
    typedef enum logic [1:0] {IDLE, SERVE, MOVE, MISS} state_t;

    localparam int MAX_A     = (SERVE_TICKS > MOVE_TICKS) ? SERVE_TICKS : MOVE_TICKS;
    localparam int MAX_TICKS = (MAX_A > MIN_TICKS) ? MAX_A : MIN_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [COORD_W-1:0] CENTRE_X   = COORD_W'(GAME_WIDTH / 2);
    localparam logic [COORD_W-1:0] CENTRE_Y   = COORD_W'(GAME_HEIGHT / 2);
    localparam logic [COORD_W-1:0] X_LEFT     = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_RIGHT    = COORD_W'(GAME_WIDTH - 2);
    localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_TOP      = COORD_W'(1);
    localparam logic [COORD_W-1:0] Y_BOTTOM   = COORD_W'(GAME_HEIGHT - 2);
    localparam logic [COORD_W:0]   PAD_LEN    = (COORD_W + 1)'(PADDLE_HEIGHT);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS - 1);

    state_t             state_q;
    logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
    logic [1:0]         dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, period;
    logic               draw_q, score_p1_q, score_p2_q;
    logic               at_left, at_right, in_pad1, in_pad2, miss_left, miss_right, step;

    // One extra bit keeps paddle_y + PADDLE_HEIGHT from wrapping near the bottom.
    assign in_pad1 = ({1'b0, y_q} >= {1'b0, i_paddle1_y}) &&
                     ({1'b0, y_q} <  {1'b0, i_paddle1_y} + PAD_LEN);
    assign in_pad2 = ({1'b0, y_q} >= {1'b0, i_paddle2_y}) &&
                     ({1'b0, y_q} <  {1'b0, i_paddle2_y} + PAD_LEN);

    assign at_left    = (x_q == X_LEFT) && !dir_q[0];
    assign at_right   = (x_q == X_RIGHT) && dir_q[0];
    assign miss_left  = at_left && !in_pad1;
    assign miss_right = at_right && !in_pad2;
    assign step       = (cnt_q == period - CNT_W'(1));

    always_comb begin
        dir_d = dir_q;
        if (y_q == Y_TOP && dir_q[1]) begin
            dir_d[1] = 1'b0;
        end else if (y_q == Y_BOTTOM && !dir_q[1]) begin
            dir_d[1] = 1'b1;
        end
        if (at_left && in_pad1) begin
            dir_d[0] = 1'b1;
        end
        if (at_right && in_pad2) begin
            dir_d[0] = 1'b0;
        end
        y_d = dir_d[1] ? y_q - COORD_W'(1) : y_q + COORD_W'(1);
        if (miss_left) begin
            x_d = '0;
        end else if (miss_right) begin
            x_d = X_MAX;
        end else begin
            x_d = dir_d[0] ? x_q + COORD_W'(1) : x_q - COORD_W'(1);
        end
    end

`ifdef BALL_SPEEDUP_EN
    logic [CNT_W-1:0] period_q, period_hit;

    assign period     = period_q;
    assign period_hit = (int'(period_q) < MIN_TICKS + SPEEDUP_STEP) ? CNT_W'(MIN_TICKS)
                                                                     : period_q - CNT_W'(SPEEDUP_STEP);

    // SERVE is only ever entered from IDLE or MISS, so restoring there covers every serve.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enabled || state_q == IDLE || state_q == MISS) begin
            period_q <= CNT_W'(MOVE_TICKS);
        end else if (state_q == MOVE && step && ((at_left && in_pad1) || (at_right && in_pad2))) begin
            period_q <= period_hit;
        end
    end
`else
    assign period = CNT_W'(MOVE_TICKS);
`endif

    always_ff @(posedge i_clk) begin
        draw_q     <= 1'b0;
        score_p1_q <= 1'b0;
        score_p2_q <= 1'b0;
        if (i_rst || !i_enabled) begin
            state_q <= IDLE;
            x_q     <= CENTRE_X;
            y_q     <= CENTRE_Y;
            dir_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            draw_q <= (state_q != IDLE) && (i_col == x_q) && (i_row == y_q);
            case (state_q)
                IDLE: begin
                    state_q <= SERVE;
                    cnt_q   <= '0;
                end
                SERVE: begin
                    if (cnt_q == SERVE_LAST) begin
                        state_q <= MOVE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                MOVE: begin
                    if (step) begin
                        cnt_q <= '0;
                        x_q   <= x_d;
                        y_q   <= y_d;
                        dir_q <= dir_d;
                        if (miss_left || miss_right) begin
                            state_q    <= MISS;
                            score_p2_q <= miss_left;
                            score_p1_q <= miss_right;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                MISS: begin
                    // x is 0 or GAME_WIDTH-1 here; serve back toward the side that missed.
                    state_q <= SERVE;
                    x_q     <= CENTRE_X;
                    y_q     <= CENTRE_Y;
                    dir_q   <= {1'b0, x_q != '0};
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_draw           = draw_q;
    assign o_ball_x         = x_q;
    assign o_ball_y         = y_q;
    assign o_ball_direction = dir_q;
    assign o_score_p1       = score_p1_q;
    assign o_score_p2       = score_p2_q;
endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 The block SHALL have parameter GAME_WIDTH, default 40, playfield columns.
REQ-002 The block SHALL have parameter GAME_HEIGHT, default 30, playfield rows.
REQ-003 The block SHALL have parameter COORD_W, default 6, coordinate width; it must be at least clog2(max(GAME_WIDTH, GAME_HEIGHT)).
REQ-004 The block SHALL have parameter MOVE_TICKS, default 625000, the initial number of clocks per ball step.
REQ-005 The block SHALL have parameter SERVE_TICKS, default 25000000, the serve-delay clocks.
REQ-006 The block SHALL have parameter PADDLE_HEIGHT, default 6, paddle length in rows.
REQ-007 The block SHALL have parameter SPEEDUP_STEP, default 25000, the clocks removed from the step period per paddle hit.
REQ-008 The block SHALL have parameter MIN_TICKS, default 200000, the step-period floor.
REQ-009 Clock and reset SHALL be: i_clk, input, 1, sole clock; i_rst, input, 1, synchronous active-high reset.
REQ-010 Inputs SHALL be: i_enabled, 1, game running; i_col and i_row, COORD_W each, pixel-cell scan position; i_paddle1_y and i_paddle2_y, COORD_W each, top row of the left paddle (column 0) and right paddle (column GAME_WIDTH-1).
REQ-011 Outputs SHALL be: o_draw, 1, registered ball-cell hit; o_ball_x and o_ball_y, COORD_W each, ball position; o_ball_direction, 2, bit0 1=east/0=west, bit1 1=north/0=south; o_score_p1 and o_score_p2, 1 each, one-cycle score pulses.

Function
REQ-012 The FSM SHALL have states IDLE, SERVE, MOVE and MISS.
REQ-013 IDLE SHALL hold the ball at (GAME_WIDTH/2, GAME_HEIGHT/2) with direction 00 and cleared counters, and SHALL go to SERVE on the first clock with i_enabled=1.
REQ-014 SERVE SHALL hold the ball at centre for SERVE_TICKS clocks, then go to MOVE with the tick counter cleared.
REQ-015 In MOVE the tick counter SHALL count 0 to period-1; when it reaches period-1 it SHALL wrap to 0 and perform exactly one step in that cycle.
REQ-016 Each step SHALL first compute the new direction, then move x by -1/+1 and y by +1/-1 using the new direction.
REQ-017 Vertical reflection: at y==1 moving north, bit1 SHALL become 0; at y==GAME_HEIGHT-2 moving south, bit1 SHALL become 1.
REQ-018 Left edge (x==1, moving west): if i_paddle1_y <= y < i_paddle1_y+PADDLE_HEIGHT, bit0 SHALL become 1 (hit); otherwise the ball SHALL move to x=0 and the FSM SHALL go to MISS with a p2 score.
REQ-019 Right edge (x==GAME_WIDTH-2, moving east) SHALL behave symmetrically with i_paddle2_y; a miss sets x=GAME_WIDTH-1 and scores p1.
REQ-020 The paddle-range comparison SHALL use COORD_W+1 bits so that the sum i_paddle_y+PADDLE_HEIGHT cannot wrap.
REQ-021 In a corner (edge reflection and vertical reflection in the same step), both direction bits SHALL update in that step.
REQ-022 MISS SHALL last exactly one cycle with the matching o_score_pN=1, then go to SERVE with the ball centred and bit0 pointing toward the player who missed and bit1=0.
REQ-023 o_draw SHALL be registered with 1-cycle latency: it is 1 when i_col==o_ball_x and i_row==o_ball_y and the state is not IDLE, otherwise 0.
REQ-024 i_enabled=0 in any state SHALL force IDLE at the next edge; no score pulse SHALL be issued in that cycle.

Reset
REQ-025 i_rst SHALL dominate i_enabled, putting the block in IDLE with the ball at centre, direction 00, all counters 0, period=MOVE_TICKS, and o_draw=o_score_p1=o_score_p2=0.
REQ-026 Reset asserted mid-step or during MISS SHALL cancel any pending score pulse.

Configuration
REQ-027 With BALL_SPEEDUP_EN defined, each paddle hit SHALL reduce the period by SPEEDUP_STEP, saturating at MIN_TICKS, and each entry to SERVE SHALL restore the period to MOVE_TICKS.
REQ-028 Without BALL_SPEEDUP_EN, the period SHALL be constant at MOVE_TICKS and no speed-up logic SHALL be synthesised.

Verification
REQ-029 Serve: 16x12 field, SERVE_TICKS=8, MOVE_TICKS=4, enable -> ball at (8,6) for 8 clocks, first step at MOVE cycle 4 to (7,7).
REQ-030 Hit: ball (1,5) heading west, i_paddle1_y=3, PADDLE_HEIGHT=4 -> next step to (2,6), bit0=1, no score.
REQ-031 Miss: ball (1,9) heading west, i_paddle1_y=0 -> x=0, one-cycle o_score_p2, then SERVE at (8,6) with bit0=0.
REQ-032 Corner: ball (14,1) heading NE -> direction 00, next position (13,2).
REQ-033 Speed-up (macro on): MOVE_TICKS=10, SPEEDUP_STEP=4, MIN_TICKS=3, three hits -> periods 6, 3, 3.
REQ-034 Reset/disable: i_rst or i_enabled=0 asserted during MOVE -> next cycle IDLE, ball (8,6), o_draw=0, no score pulse.
